// File: rtl/punc_control_pkg.sv
// Shared definitions for the PUnC control path: opcodes, FSM state encoding
// and every datapath select encoding driven by punc_control.
package punc_control_pkg;

  // LC3 opcodes (ir[15:12])
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Memory read address: PC, PC+sext9, base+sext6, LDI pointer register
  localparam logic [1:0] MEM_R_ADDR_SEL_PC      = 2'd0;
  localparam logic [1:0] MEM_R_ADDR_SEL_A       = 2'd1;
  localparam logic [1:0] MEM_R_ADDR_SEL_B       = 2'd2;
  localparam logic [1:0] MEM_R_ADDR_SEL_LDI_REG = 2'd3;

  // Memory write address: PC+sext9, base+sext6, memory read data (STI)
  localparam logic [1:0] MEM_W_ADDR_SEL_A       = 2'd0;
  localparam logic [1:0] MEM_W_ADDR_SEL_B       = 2'd1;
  localparam logic [1:0] MEM_W_ADDR_SEL_MEMDATA = 2'd2;

  localparam logic       MEM_W_DATA_SEL_RF      = 1'b0;

  // Read port 0: A = ir[8:6], B = ir[11:9]; read port 1: A = ir[2:0], B = ir[8:6]
  localparam logic       RF_R0_ADDR_SEL_A       = 1'b0;
  localparam logic       RF_R0_ADDR_SEL_B       = 1'b1;
  localparam logic       RF_R1_ADDR_SEL_A       = 1'b0;
  localparam logic       RF_R1_ADDR_SEL_B       = 1'b1;

  // Register write data: ALU, memory, PC, PC+sext9
  localparam logic [1:0] RF_W_DATA_SEL_ALU      = 2'd0;
  localparam logic [1:0] RF_W_DATA_SEL_MEM      = 2'd1;
  localparam logic [1:0] RF_W_DATA_SEL_PC       = 2'd2;
  localparam logic [1:0] RF_W_DATA_SEL_A        = 2'd3;

  // Register write address: A = ir[11:9], or R7 for JSR/JSRR
  localparam logic       RF_W_ADDR_SEL_A        = 1'b0;
  localparam logic       RF_W_ADDR_SEL_R7       = 1'b1;

  // PC load source: A = PC+sext9, B = register, C = PC+sext11
  localparam logic [1:0] PC_LD_DATA_SEL_A       = 2'd0;
  localparam logic [1:0] PC_LD_DATA_SEL_B       = 2'd1;
  localparam logic [1:0] PC_LD_DATA_SEL_C       = 2'd2;

  localparam logic [2:0] ALU_FN_ADD             = 3'd0;
  localparam logic [2:0] ALU_FN_ADD_I           = 3'd1;
  localparam logic [2:0] ALU_FN_AND             = 3'd2;
  localparam logic [2:0] ALU_FN_AND_I           = 3'd3;
  localparam logic [2:0] ALU_FN_NOT             = 3'd4;

  localparam logic       COND_LD_DATA_SEL_ALU   = 1'b0;
  localparam logic       COND_LD_DATA_SEL_RF    = 1'b1;

endpackage

// File: rtl/punc_control.sv
// PUnC control FSM: sequences the datapath through reset, fetch, decode,
// execute and halt. All strobes are combinational from state, ir and n/z/p.
module punc_control
  import punc_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic             n,
  input  logic             z,
  input  logic             p,
  output logic             mem_w_en,
  output logic [1:0]       mem_w_addr_sel,
  output logic             mem_w_data_sel,
  output logic [1:0]       mem_r_addr_sel,
  output logic             rf_w_en,
  output logic             rf_r0_addr_sel,
  output logic             rf_r1_addr_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             rf_w_addr_sel,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic [1:0]       pc_ld_data_sel,
  output logic [2:0]       alu_sel,
  output logic             cond_ld,
  output logic             cond_ld_data_sel,
  output logic             ldi_reg_ld,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;
  logic       br_taken;

  assign opcode   = ir[15:12];
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  // State register; reset always returns to INIT
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:   next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   next_state = (opcode == OP_LDI) ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2:  next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_INIT;
    endcase
  end

  // Retired-instruction counter: counts each DECODE->EXEC transition
  always_ff @(posedge clk) begin
    if (rst)
      instr_count <= '0;
    else if (state == ST_DECODE && next_state == ST_EXEC)
      instr_count <= instr_count + 1'b1;
  end

  // Output decode from state, opcode and condition codes
  always_comb begin
    mem_w_en         = 1'b0;
    mem_w_addr_sel   = MEM_W_ADDR_SEL_A;
    mem_w_data_sel   = MEM_W_DATA_SEL_RF;
    mem_r_addr_sel   = MEM_R_ADDR_SEL_PC;
    rf_w_en          = 1'b0;
    rf_r0_addr_sel   = RF_R0_ADDR_SEL_A;
    rf_r1_addr_sel   = RF_R1_ADDR_SEL_A;
    rf_w_data_sel    = RF_W_DATA_SEL_ALU;
    rf_w_addr_sel    = RF_W_ADDR_SEL_A;
    ir_ld            = 1'b0;
    pc_ld            = 1'b0;
    pc_clr           = 1'b0;
    pc_inc           = 1'b0;
    pc_ld_data_sel   = PC_LD_DATA_SEL_A;
    alu_sel          = ALU_FN_ADD;
    cond_ld          = 1'b0;
    cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
    ldi_reg_ld       = 1'b0;
    halted           = 1'b0;
    case (state)
      ST_INIT: pc_clr = 1'b1;
      ST_FETCH: begin
        mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
        ir_ld          = 1'b1;
        pc_inc         = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_r0_addr_sel   = RF_R0_ADDR_SEL_A;
            rf_r1_addr_sel   = RF_R1_ADDR_SEL_A;
            if (opcode == OP_NOT)      alu_sel = ALU_FN_NOT;
            else if (opcode == OP_ADD) alu_sel = ir[5] ? ALU_FN_ADD_I : ALU_FN_ADD;
            else                       alu_sel = ir[5] ? ALU_FN_AND_I : ALU_FN_AND;
            rf_w_en          = 1'b1;
            rf_w_addr_sel    = RF_W_ADDR_SEL_A;
            rf_w_data_sel    = RF_W_DATA_SEL_ALU;
            cond_ld          = 1'b1;
            cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
          end
          OP_BR: begin
            if (br_taken) begin
              pc_ld          = 1'b1;
              pc_ld_data_sel = PC_LD_DATA_SEL_A;
            end
          end
          OP_JMP: begin
            pc_ld          = 1'b1;
            pc_ld_data_sel = PC_LD_DATA_SEL_B;
            rf_r0_addr_sel = RF_R0_ADDR_SEL_A;
          end
          OP_JSR: begin
            // R7 write and PC load share one edge, so JSRR R7 uses the old R7
            rf_w_en       = 1'b1;
            rf_w_addr_sel = RF_W_ADDR_SEL_R7;
            rf_w_data_sel = RF_W_DATA_SEL_PC;
            pc_ld         = 1'b1;
            if (ir[11]) begin
              pc_ld_data_sel = PC_LD_DATA_SEL_C;
            end else begin
              pc_ld_data_sel = PC_LD_DATA_SEL_B;
              rf_r0_addr_sel = RF_R0_ADDR_SEL_A;
            end
          end
          OP_LD, OP_LDR: begin
            if (opcode == OP_LDR) begin
              mem_r_addr_sel = MEM_R_ADDR_SEL_B;
              rf_r0_addr_sel = RF_R0_ADDR_SEL_A;
            end else begin
              mem_r_addr_sel = MEM_R_ADDR_SEL_A;
            end
            rf_w_en          = 1'b1;
            rf_w_addr_sel    = RF_W_ADDR_SEL_A;
            rf_w_data_sel    = RF_W_DATA_SEL_MEM;
            cond_ld          = 1'b1;
            cond_ld_data_sel = COND_LD_DATA_SEL_RF;
          end
          OP_LEA: begin
            rf_w_en          = 1'b1;
            rf_w_addr_sel    = RF_W_ADDR_SEL_A;
            rf_w_data_sel    = RF_W_DATA_SEL_A;
            cond_ld          = 1'b1;
            cond_ld_data_sel = COND_LD_DATA_SEL_RF;
          end
          OP_ST: begin
            mem_w_en       = 1'b1;
            mem_w_addr_sel = MEM_W_ADDR_SEL_A;
            mem_w_data_sel = MEM_W_DATA_SEL_RF;
            rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
          end
          OP_STR: begin
            mem_w_en       = 1'b1;
            mem_w_addr_sel = MEM_W_ADDR_SEL_B;
            mem_w_data_sel = MEM_W_DATA_SEL_RF;
            rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
            rf_r1_addr_sel = RF_R1_ADDR_SEL_B;
          end
          OP_LDI: begin
            mem_r_addr_sel = MEM_R_ADDR_SEL_A;
            ldi_reg_ld     = 1'b1;
          end
          OP_STI: begin
            // Pointer read and indirect write complete in one cycle
            mem_r_addr_sel = MEM_R_ADDR_SEL_A;
            mem_w_addr_sel = MEM_W_ADDR_SEL_MEMDATA;
            mem_w_data_sel = MEM_W_DATA_SEL_RF;
            rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
            mem_w_en       = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        mem_r_addr_sel   = MEM_R_ADDR_SEL_LDI_REG;
        rf_w_en          = 1'b1;
        rf_w_data_sel    = RF_W_DATA_SEL_MEM;
        rf_w_addr_sel    = RF_W_ADDR_SEL_A;
        cond_ld          = 1'b1;
        cond_ld_data_sel = COND_LD_DATA_SEL_RF;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
    // A reset arriving mid-instruction must not commit any write
    if (rst) begin
      mem_w_en = 1'b0;
      rf_w_en  = 1'b0;
    end
  end

endmodule
